l1_lru_manager: RTL and testbench

//  Replacement manager for the set-associative L1 caches (L1I/L1D). Owns a per-set tree-PLRU state array.
//  It reports hit, selects the fill/victim way and flags evictions. It works alongside the per-way tag
//  (l1_ld_mem) and data (l1_dm_mem) arrays, which are read in parallel with it.
//  Two-stage flow: lookup stage (req/idx), analysis stage (tag compare in, decision out).

---
 rtl/l1_pkg.sv | 51 +++++
 rtl/l1_lru_manager_if.sv | 23 ++
 rtl/l1_lru_state_ram.sv | 28 ++
 rtl/l1_lru_manager.sv | 84 ++++++++
 tb/tb_l1_lru_manager.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/l1_pkg.sv
// Shared L1 cache constants and tree-PLRU helper functions.
// Leaves of the tree are ways in index order; node n has children 2n+1 and 2n+2.
package l1_pkg;
    localparam int WAY_NUM    = 4;
    localparam int SET_NUM    = 64;
    localparam int IDX_WIDTH  = $clog2(SET_NUM);
    localparam int WAY_IDX_W  = $clog2(WAY_NUM);
    localparam int TREE_DEPTH = WAY_IDX_W;

    typedef logic [WAY_NUM-2:0]   plru_t;
    typedef logic [WAY_NUM-1:0]   way_vect_t;
    typedef logic [IDX_WIDTH-1:0] idx_t;

    // Lowest set bit wins if the vector is not one-hot.
    function automatic logic [WAY_IDX_W-1:0] one_hot_num(way_vect_t vect);
        logic [WAY_IDX_W-1:0] num;
        num = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--)
            if (vect[i]) num = WAY_IDX_W'(i);
        return num;
    endfunction

    function automatic way_vect_t plru_victim(plru_t state);
        int    node;
        plru_t tmp;
        node = 0;
        for (int lvl = 0; lvl < TREE_DEPTH; lvl++) begin
            tmp  = state >> node;
            node = tmp[0] ? 2 * node + 2 : 2 * node + 1;
        end
        return way_vect_t'(1) << (node - (WAY_NUM - 1));
    endfunction

    // Walk from the leaf to the root, pointing each node away from the touched way.
    function automatic plru_t plru_update(plru_t state, way_vect_t way_onehot);
        plru_t s;
        int    node;
        int    parent;
        s    = state;
        node = int'(one_hot_num(way_onehot)) + WAY_NUM - 1;
        for (int lvl = 0; lvl < TREE_DEPTH; lvl++) begin
            parent = (node - 1) / 2;
            if (node % 2 == 1)
                s = s | (plru_t'(1) << parent);
            else
                s = s & ~(plru_t'(1) << parent);
            node = parent;
        end
        return s;
    endfunction
endpackage

// File: rtl/l1_lru_manager_if.sv
// Lookup/analysis bus between the L1 controller and the replacement manager.
interface l1_lru_manager_if;
    import l1_pkg::*;

    logic      req;
    idx_t      idx;
    logic      ready;
    way_vect_t tag_cmp_vect;
    way_vect_t ld_val_vect;
    logic      hit;
    logic      evict_val;
    way_vect_t way_vect;

    modport master (
        output req, idx, tag_cmp_vect, ld_val_vect,
        input  ready, hit, evict_val, way_vect
    );

    modport slave (
        input  req, idx, tag_cmp_vect, ld_val_vect,
        output ready, hit, evict_val, way_vect
    );
endinterface

// File: rtl/l1_lru_state_ram.sv
// Per-set PLRU state array: one synchronous read port, one write port.
// A same-cycle write to the read address is forwarded to the read data.
module l1_lru_state_ram
    import l1_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  rd_en,
    input  idx_t  rd_addr,
    output plru_t rd_data,
    input  logic  wr_en,
    input  idx_t  wr_addr,
    input  plru_t wr_data
);
    plru_t mem [SET_NUM];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
endmodule

// File: rtl/l1_lru_manager.sv
// L1 replacement manager: hit detection, fill/victim way selection and tree-PLRU upkeep.
// Stage 1 reads the set state; stage 2 decides combinationally and writes the state back.
module l1_lru_manager
    import l1_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    l1_lru_manager_if.slave bus
);
    logic      req_r;
    idx_t      idx_r;
    logic      ready_r;
    idx_t      init_cnt;
    logic      accept;
    plru_t     state_r;
    way_vect_t hv;
    way_vect_t inval;
    way_vect_t way_sel;
    logic      hit_c;
    logic      evict_c;
    logic      wr_en;
    idx_t      wr_addr;
    plru_t     wr_data;

    assign accept = bus.req & ready_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r    <= 1'b0;
            idx_r    <= '0;
            ready_r  <= 1'b0;
            init_cnt <= '0;
        end else begin
            req_r <= accept;
            if (accept)
                idx_r <= bus.idx;
            if (!ready_r) begin
                init_cnt <= init_cnt + idx_t'(1);
                if (init_cnt == idx_t'(SET_NUM - 1))
                    ready_r <= 1'b1;
            end
        end
    end

    always_comb begin
        hv      = bus.tag_cmp_vect & bus.ld_val_vect;
        inval   = ~bus.ld_val_vect;
        hit_c   = 1'b0;
        evict_c = 1'b0;
        way_sel = '0;
        if (req_r) begin
            if (|hv) begin
                hit_c   = 1'b1;
                way_sel = hv & (-hv);
            end else if (|inval) begin
                way_sel = inval & (-inval);
            end else begin
                way_sel = plru_victim(state_r);
                evict_c = 1'b1;
            end
        end
    end

    // The init sweep owns the write port until ready; afterwards only stage 2 writes.
    assign wr_en   = ~ready_r | req_r;
    assign wr_addr = ready_r ? idx_r : init_cnt;
    assign wr_data = ready_r ? plru_update(state_r, way_sel) : '0;

    l1_lru_state_ram u_state_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (accept),
        .rd_addr (bus.idx),
        .rd_data (state_r),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign bus.ready     = ready_r;
    assign bus.hit       = hit_c;
    assign bus.evict_val = evict_c;
    assign bus.way_vect  = way_sel;
endmodule

// File: tb/tb_l1_lru_manager.sv
// Bench for l1_lru_manager: directed scenarios with literal expectations, then random traffic
// checked every cycle against a per-set PLRU tree model.
module tb_l1_lru_manager;
    import l1_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;

    l1_lru_manager_if bus();

    l1_lru_manager dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // model: tree bits per set, a pending stage-2 request, and the sweep progress
    bit m_plru [SET_NUM][WAY_NUM-1];
    bit m_req_r;
    int m_idx_r;
    int m_sweep;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sel(int s, int cmp, int ld, output bit h, output bit ev);
        int hv;
        int node;
        hv = cmp & ld;
        h  = 1'b0;
        ev = 1'b0;
        if (hv != 0) begin
            h = 1'b1;
            for (int i = 0; i < WAY_NUM; i++)
                if (((hv >> i) & 1) == 1) return i;
        end
        for (int i = 0; i < WAY_NUM; i++)
            if (((ld >> i) & 1) == 0) return i;
        ev   = 1'b1;
        node = 0;
        while (node < WAY_NUM - 1)
            node = 2 * node + 1 + int'(m_plru[s][node]);
        return node - (WAY_NUM - 1);
    endfunction

    function automatic void model_touch(int s, int way);
        int node;
        int parent;
        node = way + WAY_NUM - 1;
        while (node > 0) begin
            parent = (node - 1) / 2;
            m_plru[s][parent] = (node == 2 * parent + 1);
            node = parent;
        end
    endfunction

    always @(negedge clk) begin
        bit eh;
        bit ee;
        int ew;
        int sel;
        bit acc;
        #2;
        if (!rst_n) begin
            chk("rst_hit",   int'(bus.hit),       0);
            chk("rst_evict", int'(bus.evict_val), 0);
            chk("rst_way",   int'(bus.way_vect),  0);
            chk("rst_ready", int'(bus.ready),     0);
            m_req_r = 1'b0;
            m_sweep = 0;
            foreach (m_plru[s, n]) m_plru[s][n] = 1'b0;
        end else begin
            eh  = 1'b0;
            ee  = 1'b0;
            ew  = 0;
            sel = 0;
            if (m_req_r) begin
                sel = model_sel(m_idx_r, int'(bus.tag_cmp_vect), int'(bus.ld_val_vect), eh, ee);
                ew  = 1 << sel;
            end
            chk("cyc_hit",   int'(bus.hit),       int'(eh));
            chk("cyc_evict", int'(bus.evict_val), int'(ee));
            chk("cyc_way",   int'(bus.way_vect),  ew);
            chk("cyc_ready", int'(bus.ready),     int'(m_sweep >= SET_NUM));
            if (m_req_r) model_touch(m_idx_r, sel);
            acc = bus.req && (m_sweep >= SET_NUM);
            if (m_sweep < SET_NUM) m_sweep++;
            m_req_r = acc;
            m_idx_r = int'(bus.idx);
        end
    end

    task automatic step(bit r, int i, int cmp, int ld);
        @(negedge clk);
        bus.req          = r;
        bus.idx          = idx_t'(i);
        bus.tag_cmp_vect = way_vect_t'(cmp);
        bus.ld_val_vect  = way_vect_t'(ld);
    endtask

    task automatic lit(string n, int h, int e, int w);
        #2;
        chk({n, "_hit"},   int'(bus.hit),       h);
        chk({n, "_evict"}, int'(bus.evict_val), e);
        chk({n, "_way"},   int'(bus.way_vect),  w);
    endtask

    task automatic wait_ready(string n);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = bus.ready;
        end
        chk(n, seen ? edges : -1, SET_NUM);
    endtask

    initial begin
        int cmp;
        int ld;
        rst_n            = 1'b1;
        bus.req          = 1'b0;
        bus.idx          = '0;
        bus.tag_cmp_vect = '0;
        bus.ld_val_vect  = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 1'b1;
        bus.idx = idx_t'(3);
        step(0, 0, 'hF, 'hF);
        lit("init_req", 0, 0, 0);
        wait_ready("sweep1_len");

        step(1, 5, 0, 0);
        step(0, 0, 'b0000, 'b0001);
        lit("cold_fill", 0, 0, 'b0010);

        step(1, 7, 0, 0);
        step(0, 0, 'b0100, 'b1111);
        lit("hit7", 1, 0, 'b0100);

        for (int w = 0; w < WAY_NUM; w++) begin
            step(1, 9, 0, 0);
            step(0, 0, 1 << w, 'hF);
            lit($sformatf("hit9_w%0d", w), 1, 0, 1 << w);
        end
        step(1, 9, 0, 0);
        step(0, 0, 0, 'hF);
        lit("evict9", 0, 1, 'b0001);

        step(1, 12, 0, 0);
        step(1, 12, 'b0001, 'hF);
        lit("b2b_hit", 1, 0, 'b0001);
        step(1, 13, 0, 'hF);
        lit("b2b_bypass", 0, 1, 'b0100);
        step(0, 0, 0, 'hF);
        lit("idx13", 0, 1, 'b0001);

        step(1, 20, 0, 0);
        step(0, 0, 'b0100, 'hF);
        lit("pre_rst", 1, 0, 'b0100);
        #1 rst_n = 1'b0;
        #1;
        lit("mid_rst", 0, 0, 0);
        chk("mid_rst_ready", int'(bus.ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep2_len");

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: cmp = 0;
                9:          cmp = int'($urandom_range(0, 15));
                default:    cmp = 1 << $urandom_range(0, 3);
            endcase
            ld = ($urandom_range(0, 1) == 1) ? 'hF : int'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 70, int'($urandom_range(0, 7)), cmp, ld);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
